// File: rtl/router_1xn_sync.sv
// Single-clock 1xN packet router: parses header/payload/parity packets from one
// source and steers each whole packet into one of NUM_PORTS output FIFOs.
module router_1xn_sync #(
    parameter int NUM_PORTS  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk1,
    input  logic                            reset,
    input  logic                            packet_valid_i,
    input  logic [DATA_WIDTH-1:0]           packet_in,
    input  logic [NUM_PORTS-1:0]            read_enable,
    output logic [NUM_PORTS-1:0]            packet_valid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] packet_out,
    output logic                            stop_packet_send,
    output logic                            err,
    output logic                            drop
);

    localparam int DEST_W = $clog2(NUM_PORTS);
    localparam int LEN_W  = DATA_WIDTH - DEST_W;
    localparam int CNT_W  = LEN_W + 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_HDR,
        PAYLOAD,
        PARITY,
        DROP
    } state_t;

    state_t                state_q, state_d;
    logic [DEST_W-1:0]     dest_q, dest_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] par_q, par_d;
    logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic                  err_q, err_d;
    logic                  drop_q, drop_d;

    logic [NUM_PORTS-1:0]  full;
    logic [NUM_PORTS-1:0]  empty;
    logic [NUM_PORTS-1:0]  push_sel;
    logic                  push_en;
    logic [DATA_WIDTH-1:0] push_word;
    logic                  stop;
    logic [DEST_W-1:0]     hdr_dest;
    logic [LEN_W-1:0]      hdr_len;
    logic                  hdr_ok;
    logic                  hdr_full;
    logic                  cur_full;

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dest_q  <= '0;
            cnt_q   <= '0;
            par_q   <= '0;
            hdr_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            hdr_q   <= hdr_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        hdr_d     = hdr_q;
        err_d     = 1'b0;
        drop_d    = 1'b0;
        push_en   = 1'b0;
        push_word = packet_in;
        stop      = 1'b0;
        push_sel  = '0;
        hdr_dest  = packet_in[DEST_W-1:0];
        hdr_len   = packet_in[DATA_WIDTH-1:DEST_W];
        hdr_ok    = 1'b0;
        hdr_full  = 1'b0;
        cur_full  = 1'b0;

        // Run-time decode: a destination not matching any port is illegal.
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (hdr_dest == DEST_W'(p)) begin
                hdr_ok   = 1'b1;
                hdr_full = full[p];
            end
            if (dest_q == DEST_W'(p)) begin
                cur_full = full[p];
            end
        end

        case (state_q)
            IDLE: begin
                if (packet_valid_i) begin
                    if (!hdr_ok) begin
                        cnt_d   = CNT_W'(hdr_len) + CNT_W'(1);
                        state_d = DROP;
                    end else begin
                        dest_d = hdr_dest;
                        cnt_d  = CNT_W'(hdr_len);
                        par_d  = packet_in;
                        if (hdr_full) begin
                            hdr_d   = packet_in;
                            state_d = HOLD_HDR;
                        end else begin
                            push_en = 1'b1;
                            state_d = (hdr_len == '0) ? PARITY : PAYLOAD;
                        end
                    end
                end
            end
            HOLD_HDR: begin
                stop = 1'b1;
                if (!cur_full) begin
                    push_en   = 1'b1;
                    push_word = hdr_q;
                    state_d   = (cnt_q == '0) ? PARITY : PAYLOAD;
                end
            end
            PAYLOAD: begin
                stop = cur_full;
                if (packet_valid_i && !cur_full) begin
                    push_en = 1'b1;
                    par_d   = par_q ^ packet_in;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                stop = cur_full;
                if (packet_valid_i && !cur_full) begin
                    push_en = 1'b1;
                    err_d   = (par_q != packet_in);
                    par_d   = '0;
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (packet_valid_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (push_en && (dest_d == DEST_W'(p))) begin
                push_sel[p] = 1'b1;
            end
        end
    end

    assign stop_packet_send = stop;
    assign err              = err_q;
    assign drop             = drop_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        logic [PTR_W-1:0]      wr_q;
        logic [PTR_W-1:0]      rd_q;
        logic [DATA_WIDTH-1:0] rdata_q;
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic                  do_push;
        logic                  do_pop;

        // Extra pointer MSB separates full from empty once the write side wraps.
        assign full[g]  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        assign empty[g] = (wr_q == rd_q);
        assign do_push  = push_sel[g] && !full[g];
        assign do_pop   = read_enable[g] && !empty[g];

        always_ff @(posedge clk1 or negedge reset) begin
            if (!reset) begin
                wr_q    <= '0;
                rd_q    <= '0;
                rdata_q <= '0;
            end else begin
                if (do_push) begin
                    wr_q <= wr_q + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_q    <= rd_q + PTR_W'(1);
                    rdata_q <= mem_q[rd_q[AW-1:0]];
                end
            end
        end

        always_ff @(posedge clk1) begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= push_word;
            end
        end

        assign packet_out[g*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
        assign packet_valid_o[g]                      = !empty[g];
    end

endmodule

// File: tb/tb_router_1xn_sync.sv
// Scoreboard bench for router_1xn_sync: a 16-deep instance for routing, parity,
// drop, hold and reset cases, and a 4-deep instance for pointer wrap and full/empty.
module tb_router_1xn_sync;

    localparam int NP = 3;

    logic            clk1 = 1'b0;
    logic            reset = 1'b0;
    logic            pv_i = 1'b0;
    logic [7:0]      pin = '0;
    logic [NP-1:0]   re = '0;
    logic [NP-1:0]   pv_o;
    logic [NP*8-1:0] pout;
    logic            stop, err, drop;

    logic            b_pv_i = 1'b0;
    logic [7:0]      b_pin = '0;
    logic [NP-1:0]   b_re = '0;
    logic [NP-1:0]   b_pv_o;
    logic [NP*8-1:0] b_pout;
    logic            b_stop, b_err, b_drop;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    bit          stop_seen = 1'b0;
    logic [7:0]  sb_q [NP][$];
    logic [7:0]  sbb_q [$];
    logic [7:0]  b_last = '0;
    logic [7:0]  pk [$];

    router_1xn_sync #(.NUM_PORTS(NP), .DATA_WIDTH(8), .FIFO_DEPTH(16)) u_dut (
        .clk1(clk1), .reset(reset), .packet_valid_i(pv_i), .packet_in(pin),
        .read_enable(re), .packet_valid_o(pv_o), .packet_out(pout),
        .stop_packet_send(stop), .err(err), .drop(drop)
    );

    router_1xn_sync #(.NUM_PORTS(NP), .DATA_WIDTH(8), .FIFO_DEPTH(4)) u_dut_b (
        .clk1(clk1), .reset(reset), .packet_valid_i(b_pv_i), .packet_in(b_pin),
        .read_enable(b_re), .packet_valid_o(b_pv_o), .packet_out(b_pout),
        .stop_packet_send(b_stop), .err(b_err), .drop(b_drop)
    );

    always #5 clk1 = ~clk1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic make_pkt(input logic [7:0] hdr, input int n, input logic [7:0] base,
                            input logic bad, output logic [7:0] w [$]);
        logic [7:0] p;
        p = hdr;
        w = {};
        w.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            w.push_back(base + 8'(i));
            p = p ^ (base + 8'(i));
        end
        w.push_back(bad ? p + 8'd1 : p);
    endtask

    task automatic send_word(input logic [7:0] w);
        int unsigned waited;
        waited = 0;
        pv_i = 1'b1;
        pin  = w;
        while (stop && waited < 100) begin
            stop_seen = 1'b1;
            tick();
            waited++;
        end
        if (waited >= 100) check_eq("accept_stall", 32'(stop), 0);
        tick();
    endtask

    task automatic send_pkt(input logic [7:0] w [$], input int port);
        foreach (w[i]) begin
            if (port >= 0) sb_q[port].push_back(w[i]);
            send_word(w[i]);
        end
        pv_i = 1'b0;
    endtask

    task automatic pop_check(input int p);
        check_eq("sb_has_entry", 32'(sb_q[p].size() != 0), 1);
        if (sb_q[p].size() != 0) check_eq("rd_data", 32'(pout[p*8 +: 8]), 32'(sb_q[p].pop_front()));
    endtask

    task automatic drain(input int p);
        int unsigned n;
        n = 0;
        while (pv_o[p] && n < 40) begin
            re[p] = 1'b1;
            tick();
            pop_check(p);
            n++;
        end
        re = '0;
        check_eq("drain_empty", 32'(pv_o[p]), 0);
        check_eq("sb_left", sb_q[p].size(), 0);
    endtask

    task automatic b_send_word(input logic [7:0] w);
        int unsigned waited;
        waited = 0;
        b_pv_i = 1'b1;
        b_pin  = w;
        while (b_stop && waited < 100) begin
            tick();
            waited++;
        end
        if (waited >= 100) check_eq("b_accept_stall", 32'(b_stop), 0);
        tick();
    endtask

    task automatic b_pop_check();
        check_eq("b_sb_has_entry", 32'(sbb_q.size() != 0), 1);
        if (sbb_q.size() != 0) begin
            b_last = sbb_q.pop_front();
            check_eq("b_rd_data", 32'(b_pout[7:0]), 32'(b_last));
        end
    endtask

    task automatic b_drain();
        int unsigned n;
        n = 0;
        while (b_pv_o[0] && n < 16) begin
            b_re[0] = 1'b1;
            tick();
            b_pop_check();
            n++;
        end
        b_re = '0;
        check_eq("b_sb_left", sbb_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check_eq("rst_valid", 32'(pv_o), 0);
        check_eq("rst_pout", 32'(pout), 0);
        check_eq("rst_stop", 32'(stop), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_drop", 32'(drop), 0);
        reset = 1'b1;
        tick();

        // good packet to port 1
        pk = '{8'h0D, 8'd11, 8'd22, 8'd33};
        pk.push_back(8'h0D ^ 8'd11 ^ 8'd22 ^ 8'd33);
        send_pkt(pk, 1);
        check_eq("good_err", 32'(err), 0);
        check_eq("good_drop", 32'(drop), 0);
        check_eq("good_valid", 32'(pv_o), 32'b010);
        tick();
        check_eq("good_err_after", 32'(err), 0);
        drain(1);

        // bad parity: delivered, err pulses for exactly one cycle
        stop_seen = 1'b0;
        pk = '{8'h0D, 8'd11, 8'd22, 8'd33};
        pk.push_back((8'h0D ^ 8'd11 ^ 8'd22 ^ 8'd33) + 8'd1);
        send_pkt(pk, 1);
        check_eq("bad_err_pulse", 32'(err), 1);
        tick();
        check_eq("bad_err_clear", 32'(err), 0);
        check_eq("bad_no_stop", 32'(stop_seen), 0);
        drain(1);

        // illegal destination 3
        pk = '{8'h0B, 8'h01, 8'h02, 8'h03};
        send_pkt(pk, -1);
        check_eq("drop_pulse", 32'(drop), 1);
        check_eq("drop_nothing_written", 32'(pv_o), 0);
        tick();
        check_eq("drop_clear", 32'(drop), 0);
        make_pkt(8'h04, 1, 8'hAA, 1'b0, pk);
        send_pkt(pk, 0);
        check_eq("after_drop_err", 32'(err), 0);
        check_eq("after_drop_valid", 32'(pv_o), 32'b001);
        drain(0);

        // fill port 2, then hold a header until space frees up
        make_pkt(8'h3A, 14, 8'h80, 1'b0, pk);
        send_pkt(pk, 2);
        check_eq("fill_stop_idle", 32'(stop), 0);
        check_eq("fill_valid", 32'(pv_o), 32'b100);
        pv_i = 1'b1;
        pin  = 8'h02;
        sb_q[2].push_back(8'h02);
        tick();
        pv_i = 1'b0;
        check_eq("hold_stop", 32'(stop), 1);
        re[2] = 1'b1;
        tick();
        pop_check(2);
        check_eq("hold_stop_after_pop", 32'(stop), 1);
        tick();
        pop_check(2);
        re = '0;
        check_eq("hdr_written_stop", 32'(stop), 0);
        sb_q[2].push_back(8'h02);
        send_word(8'h02);
        pv_i = 1'b0;
        check_eq("hold_pkt_err", 32'(err), 0);
        drain(2);

        // reset in the middle of a payload
        send_word(8'h0D);
        send_word(8'd11);
        pv_i  = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(pv_o), 0);
        check_eq("midrst_pout", 32'(pout), 0);
        check_eq("midrst_stop", 32'(stop), 0);
        check_eq("midrst_err", 32'(err | drop), 0);
        tick();
        reset = 1'b1;
        tick();
        make_pkt(8'h04, 1, 8'h3C, 1'b0, pk);
        send_pkt(pk, 0);
        check_eq("postrst_valid", 32'(pv_o), 32'b001);
        check_eq("postrst_err", 32'(err), 0);
        drain(0);

        // 4-deep instance: push with pop on empty
        b_pv_i = 1'b1;
        b_pin  = 8'h04;
        b_re[0] = 1'b1;
        sbb_q.push_back(8'h04);
        tick();
        b_re = '0;
        check_eq("b_pop_empty_out", 32'(b_pout[7:0]), 0);
        check_eq("b_push_on_empty", 32'(b_pv_o[0]), 1);
        sbb_q.push_back(8'h5A);
        b_send_word(8'h5A);
        sbb_q.push_back(8'h04 ^ 8'h5A);
        b_send_word(8'h04 ^ 8'h5A);
        b_pv_i = 1'b0;
        check_eq("b_err", 32'(b_err), 0);
        b_drain();

        // pointer wrap across several fills
        for (int k = 0; k < 4; k++) begin
            make_pkt(8'h04, 1, 8'h60 + 8'(k), 1'b0, pk);
            foreach (pk[i]) begin
                sbb_q.push_back(pk[i]);
                b_send_word(pk[i]);
            end
            b_pv_i = 1'b0;
            b_drain();
        end

        // pop on empty leaves the output register alone
        b_re[0] = 1'b1;
        tick();
        b_re = '0;
        check_eq("b_pop_empty_hold", 32'(b_pout[7:0]), 32'(b_last));
        check_eq("b_empty_valid", 32'(b_pv_o[0]), 0);

        // fill to 4, then offer a word while popping
        make_pkt(8'h04, 1, 8'hC1, 1'b0, pk);
        foreach (pk[i]) begin
            sbb_q.push_back(pk[i]);
            b_send_word(pk[i]);
        end
        sbb_q.push_back(8'h04);
        b_send_word(8'h04);
        b_pv_i = 1'b0;
        check_eq("b_full_stop", 32'(b_stop), 1);
        b_pv_i = 1'b1;
        b_pin  = 8'hC2;
        sbb_q.push_back(8'hC2);
        b_re[0] = 1'b1;
        tick();
        b_re = '0;
        b_pop_check();
        check_eq("b_push_blocked_stop", 32'(b_stop), 0);
        tick();
        b_pv_i = 1'b0;
        check_eq("b_refull_stop", 32'(b_stop), 1);
        b_drain();
        sbb_q.push_back(8'h04 ^ 8'hC2);
        b_send_word(8'h04 ^ 8'hC2);
        b_pv_i = 1'b0;
        check_eq("b_full_pkt_err", 32'(b_err), 0);
        b_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
